// File: rtl/mpu_elementwise.sv
// mpu_elementwise: sequential element-wise matrix add/subtract.
//
// Operands and op are captured on start (while idle). LANES elements are
// processed per cycle into a working register. One cycle after the last
// chunk, the working register is copied to result with a one-cycle done pulse.
// Each element uses its own adder/subtractor, so carries and borrows never
// cross element boundaries.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   request, sampled only while busy=0
//   op       in   0 = A+B, 1 = A-B, captured with start
//   matrix_a in   operand A, element (i,j) at [DATA_W*(i+DIM*j) +: DATA_W]
//   matrix_b in   operand B, same layout
//   busy     out  operation in flight
//   done     out  one-cycle pulse when result/overflow are updated
//   overflow out  any element overflowed in the last completed op
//   result   out  registered flattened result
//
// Build option MPU_ELEMENTWISE_SATURATE_EN:
//   defined   -> signed two's complement with clamping, overflow = any clamp
//   undefined -> unsigned wrap-around, overflow = any carry/borrow
module mpu_elementwise #(
  parameter int DATA_W = 8,
  parameter int DIM    = 5,
  parameter int LANES  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op,
  input  logic [DATA_W*DIM*DIM-1:0] matrix_a,
  input  logic [DATA_W*DIM*DIM-1:0] matrix_b,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic [DATA_W*DIM*DIM-1:0] result
);

  // state | meaning
  // IDLE  | waiting for start; result/overflow hold the last completed op
  // RUN   | c < NCHUNK: process chunk c; c == NCHUNK: publish and pulse done

  localparam int NELEM  = DIM * DIM;
  localparam int NCHUNK = (NELEM + LANES - 1) / LANES;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int VW     = DATA_W * NELEM;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state_q;
  logic [CW-1:0] c_q;
  logic [VW-1:0] a_q, b_q, work_q, work_d;
  logic          op_q, work_ovf_q, work_ovf_d;

  logic [DATA_W-1:0] ea, eb, er;
  logic              eo;
`ifdef MPU_ELEMENTWISE_SATURATE_EN
  logic [DATA_W-1:0] er_raw;
  logic              sb_eff;
`else
  logic [DATA_W:0]   ext;
`endif

  assign busy = (state_q == RUN);

  // Every element computes in parallel; only elements belonging to chunk c
  // are written. When c == NCHUNK no element matches, so nothing changes.
  always_comb begin
    work_d     = work_q;
    work_ovf_d = work_ovf_q;
    ea         = '0;
    eb         = '0;
    er         = '0;
    eo         = 1'b0;
`ifdef MPU_ELEMENTWISE_SATURATE_EN
    er_raw     = '0;
    sb_eff     = 1'b0;
`else
    ext        = '0;
`endif
    for (int k = 0; k < NELEM; k++) begin
      ea = a_q[k*DATA_W +: DATA_W];
      eb = b_q[k*DATA_W +: DATA_W];
`ifdef MPU_ELEMENTWISE_SATURATE_EN
      er_raw = op_q ? (ea - eb) : (ea + eb);
      // Subtraction overflows like addition of -b: same effective sign in,
      // different sign out.
      sb_eff = op_q ? ~eb[DATA_W-1] : eb[DATA_W-1];
      eo     = (ea[DATA_W-1] == sb_eff) && (er_raw[DATA_W-1] != ea[DATA_W-1]);
      if (eo)
        er = ea[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      else
        er = er_raw;
`else
      ext = op_q ? ({1'b0, ea} - {1'b0, eb}) : ({1'b0, ea} + {1'b0, eb});
      er  = ext[DATA_W-1:0];
      eo  = ext[DATA_W];
`endif
      if (c_q == CW'(k / LANES)) begin
        work_d[k*DATA_W +: DATA_W] = er;
        work_ovf_d                 = work_ovf_d | eo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      c_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      work_q     <= '0;
      work_ovf_q <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q        <= matrix_a;
            b_q        <= matrix_b;
            op_q       <= op;
            work_ovf_q <= 1'b0;
            c_q        <= '0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (c_q == CW'(NCHUNK)) begin
            result   <= work_q;
            overflow <= work_ovf_q;
            done     <= 1'b1;
            state_q  <= IDLE;
          end else begin
            work_q     <= work_d;
            work_ovf_q <= work_ovf_d;
            c_q        <= c_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_elementwise.sv
module tb_mpu_elementwise;
  localparam int W = 8;
  localparam int D = 5;
  localparam int N = D * D;
  localparam int VW = W * N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          start = 1'b0, op = 1'b0;
  logic [VW-1:0] ma = '0, mb = '0;
  logic          busy, done, overflow;
  logic [VW-1:0] result;

  logic          start2 = 1'b0, op2 = 1'b0;
  logic [VW-1:0] ma2 = '0, mb2 = '0;
  logic          busy2, done2, overflow2;
  logic [VW-1:0] result2;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mpu_elementwise #(.DATA_W(W), .DIM(D), .LANES(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .matrix_a(ma), .matrix_b(mb),
    .busy(busy), .done(done), .overflow(overflow), .result(result)
  );

  mpu_elementwise #(.DATA_W(W), .DIM(D), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op(op2),
    .matrix_a(ma2), .matrix_b(mb2),
    .busy(busy2), .done(done2), .overflow(overflow2), .result(result2)
  );

  // Stimulus only: pulse start for edge 0 and return the number of edges
  // after edge 0 until done is seen (0 if the bound expired).
  task automatic run_op(input logic o, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        output int lat);
    op = o; ma = a; mb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ma = '1; mb = '1; op = ~o;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
  endtask

  function automatic logic [VW-1:0] fill_ramp_a();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(k + 1);
    return v;
  endfunction

  function automatic logic [VW-1:0] fill_ramp_b();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(25 - k);
    return v;
  endfunction

  function automatic logic [VW-1:0] fill_const(input logic [W-1:0] x);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = x;
    return v;
  endfunction

  function automatic logic [VW-1:0] sub_expected();
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(2 * k - 24);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, overflow} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got busy/done/ovf=%b want 000", {busy, done, overflow});
    end
    n_cmp++;
    if (result !== '0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0", result);
    end
  endtask

  task automatic test_sub();
    int lat;
    logic [VW-1:0] prev;
    prev = result;
    op = 1'b1; ma = fill_ramp_a(); mb = fill_ramp_b(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ma = '0; mb = '0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
      if (n == 3) begin
        n_cmp++;
        if (result !== prev) begin
          n_fail++; $display("FAIL sub_partial_hidden: result changed mid-run to %h", result);
        end
      end
    end
    n_cmp++;
    if (lat != 6) begin n_fail++; $display("FAIL sub_latency: got %0d want 6", lat); end
    n_cmp++;
    if (result !== sub_expected()) begin
      n_fail++; $display("FAIL sub_result: got %h want %h", result, sub_expected());
    end
    n_cmp++;
    if (result[0 +: W] !== 8'd232 || result[12*W +: W] !== 8'd0 || result[24*W +: W] !== 8'd24) begin
      n_fail++; $display("FAIL sub_corners: got k0=%0d k12=%0d k24=%0d want 232 0 24",
                         result[0 +: W], result[12*W +: W], result[24*W +: W]);
    end
    n_cmp++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL sub_overflow: got %b want 1", overflow); end
  endtask

  task automatic test_add();
    int lat;
    run_op(1'b0, fill_ramp_a(), fill_ramp_b(), lat);
    n_cmp++;
    if (lat != 6) begin n_fail++; $display("FAIL add_latency: got %0d want 6", lat); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_at_done: got %b want 0", busy); end
    n_cmp++;
    if (result !== fill_const(8'd26)) begin
      n_fail++; $display("FAIL add_result: got %h want all 1a", result);
    end
    n_cmp++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL add_overflow: got %b want 0", overflow); end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_width: got %b want 0", done); end
  endtask

  task automatic test_lanes2();
    int lat;
    op2 = 1'b0; ma2 = fill_const(8'hFF); mb2 = fill_const(8'h01); start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0; ma2 = '0; mb2 = '0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done2) begin lat = n; break; end
    end
    n_cmp++;
    if (lat != 14) begin n_fail++; $display("FAIL lanes2_latency: got %0d want 14", lat); end
    n_cmp++;
    if (result2 !== '0) begin n_fail++; $display("FAIL lanes2_result: got %h want 0", result2); end
    n_cmp++;
    if (result2[24*W +: W] !== 8'd0) begin
      n_fail++; $display("FAIL lanes2_elem24: got %0d want 0", result2[24*W +: W]);
    end
    n_cmp++;
    if (overflow2 !== 1'b1) begin n_fail++; $display("FAIL lanes2_overflow: got %b want 1", overflow2); end
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    op = 1'b1; ma = fill_ramp_a(); mb = fill_ramp_b(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 2) begin
        op = 1'b0; ma = fill_const(8'h11); mb = fill_const(8'h22); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
    n_cmp++;
    if (lat != 6) begin n_fail++; $display("FAIL ignore_latency: got %0d want 6", lat); end
    n_cmp++;
    if (result !== sub_expected()) begin
      n_fail++; $display("FAIL ignore_result: got %h want %h", result, sub_expected());
    end
    extra = 0;
    for (int n = 0; n < 15; n++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_cmp++;
    if (extra != 0) begin n_fail++; $display("FAIL ignore_no_second_done: got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat;
    op = 1'b1; ma = fill_ramp_a(); mb = fill_ramp_b(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      // Hold start high during the cycle where done is expected.
      if (n == 6) begin
        op = 1'b0; ma = fill_const(8'h30); mb = fill_const(8'h05); start = 1'b1;
      end
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    n_cmp++;
    if (lat != 6) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 6", lat); end
    @(posedge clk); #1;
    start = 1'b0; ma = '0; mb = '0;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accepted: busy got %b want 1", busy); end
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin lat = n; break; end
    end
    n_cmp++;
    if (lat != 6) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 6", lat); end
    n_cmp++;
    if (result !== fill_const(8'h35) || overflow !== 1'b0) begin
      n_fail++; $display("FAIL b2b_result: got %h ovf %b want all 35 ovf 0", result, overflow);
    end
  endtask

  task automatic test_rst_during_run();
    int extra;
    op = 1'b1; ma = fill_ramp_a(); mb = fill_ramp_b(); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, overflow} !== 3'b000 || result !== '0) begin
      n_fail++; $display("FAIL rst_abort: got busy/done/ovf=%b result=%h want 000 and 0",
                         {busy, done, overflow}, result);
    end
    extra = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    n_cmp++;
    if (extra != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d want 0", extra); end
  endtask

  task automatic test_after_reset();
    int lat;
    run_op(1'b0, fill_const(8'h10), fill_const(8'h20), lat);
    n_cmp++;
    if (lat != 6 || result !== fill_const(8'h30)) begin
      n_fail++; $display("FAIL after_reset: lat %0d result %h want 6 and all 30", lat, result);
    end
  endtask

`ifdef MPU_ELEMENTWISE_SATURATE_EN
  task automatic test_saturate();
    int lat;
    run_op(1'b1, fill_const(8'd100), fill_const(8'h9C), lat);
    n_cmp++;
    if (result !== fill_const(8'd127) || overflow !== 1'b1) begin
      n_fail++; $display("FAIL sat_pos: got %h ovf %b want all 7f ovf 1", result, overflow);
    end
    run_op(1'b1, fill_const(8'h80), fill_const(8'd1), lat);
    n_cmp++;
    if (result !== fill_const(8'h80) || overflow !== 1'b1) begin
      n_fail++; $display("FAIL sat_neg: got %h ovf %b want all 80 ovf 1", result, overflow);
    end
    run_op(1'b1, fill_const(8'd5), fill_const(8'd3), lat);
    n_cmp++;
    if (result !== fill_const(8'd2) || overflow !== 1'b0) begin
      n_fail++; $display("FAIL sat_none: got %h ovf %b want all 02 ovf 0", result, overflow);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef MPU_ELEMENTWISE_SATURATE_EN
    test_saturate();
`else
    test_sub();
    test_add();
    test_lanes2();
    test_ignore_start();
    test_back_to_back();
`endif
    test_rst_during_run();
    test_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mpu_elementwise.md
Name: mpu_elementwise

Overview:
- Sequential element-wise matrix add/subtract unit for the MPU datapath.
- Next generation of the single-shot flat-vector subtractor. Differences:
  - Element width, matrix dimension and lanes per cycle are parametrised.
  - Add and subtract are run-time selectable.
  - Carries and borrows never cross element boundaries.
- Operands are captured on a start handshake and processed LANES elements per cycle. The full result is presented with a one-cycle done pulse.

Parameters:
- DATA_W, 8: element width in bits.
- DIM, 5: matrix is DIM x DIM.
- LANES, 5: elements processed per cycle, 1..DIM*DIM.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only when busy=0.
- op  in  1  0 = add (A+B), 1 = subtract (A-B). Captured with start.
- matrix_a  in  DATA_W*DIM*DIM  operand A, flattened.
- matrix_b  in  DATA_W*DIM*DIM  operand B, flattened.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when result is updated.
- overflow  out  1  any element overflowed in the last completed op.
- result  out  DATA_W*DIM*DIM  flattened result, registered.

Behaviour:
- Reset and clock:
  - One clock. Reset is synchronous and active-high, on ports clk/rst.
  - On reset: state=IDLE, busy=0, done=0, overflow=0, result=0, chunk index=0.
- Layout: element (i,j) occupies bits [DATA_W*(i+DIM*j) +: DATA_W]. Linear element index k = i+DIM*j.
- Arithmetic:
  - Each element is computed modulo 2^DATA_W, independently of its neighbours.
  - No carry or borrow propagates between elements.
- States: IDLE, RUN.
  - IDLE: busy=0. If start=1, capture matrix_a, matrix_b and op into internal registers, clear the working overflow flag, set chunk index c=0, and go to RUN.
  - RUN: busy=1. Each cycle compute elements k = c*LANES .. c*LANES+LANES-1 into a working result register, then c++.
    - Lanes with k >= DIM*DIM are ignored, so the last chunk may be partial.
  - Completion: after the cycle processing the final chunk (c = NCHUNK-1, NCHUNK = ceil(DIM*DIM/LANES)):
    - next cycle: the working register is copied to result, overflow is updated, done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency:
  - start sampled at edge 0 -> done high after edge NCHUNK+1. Defaults: NCHUNK=5.
  - Back-to-back: start may be high in the same cycle done is high and is accepted, since busy=0.
- Operand independence: inputs may change freely after start is accepted; only captured copies are used.
- start while busy=1: ignored, with no queuing.
- Output stability: result and overflow hold their values between done pulses. Partial results are never visible on result.
- overflow (default build): OR over all elements of unsigned carry-out (add) or borrow (sub), i.e. a < b.
- rst during RUN: abort immediately to reset values. A subsequent start behaves normally.

Optional Feature:
- Macro: MPU_ELEMENTWISE_SATURATE_EN.
- Defined:
  - Elements are treated as signed two's complement.
  - Each result is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - overflow = any element clamped.
- Undefined:
  - Unsigned wrap-around arithmetic.
  - overflow = any carry/borrow, as above.
- Timing and handshake are identical in both builds.

Test Plan:
- Default params, op=1, A elements k=0..24 = k+1, B elements = 25-k -> after 6 cycles done=1, result[k] = (2k-24) mod 256 (k=0: 232, k=12: 0, k=24: 24), overflow=1; no cross-element borrow.
- Same operands, op=0 -> every element 26, overflow=0; done exactly one cycle, busy falls with done.
- LANES=2 (NCHUNK=13): A all 255, B all 1, op=0 -> done 14 cycles after start, all elements 0, overflow=1; element 24 (partial chunk) correct.
- start pulsed at cycle 2 of a busy operation with different operands -> ignored; result matches the first operands only; no second done. start held high at the done cycle -> a new operation runs.
- rst asserted at cycle 3 of RUN -> next cycle busy=0, done=0, result=0, overflow=0; no done pulse follows.
- MPU_ELEMENTWISE_SATURATE_EN: A=100, B=-100 (0x9C), op=1 -> 127, overflow=1; A=-128, B=1, op=1 -> -128 (0x80), overflow=1; A=5, B=3, op=1 -> 2, overflow=0.
